// File: rtl/csa_pipe.sv
// rtl/csa_pipe.sv - pipelined parametrised carry-skip adder with valid/ready handshake
//
// Purpose: a+b+cin over WIDTH bits, built from BLOCK-bit ripple groups with a
// group-propagate bypass; the carry is registered every GPS groups, so an add
// spends LAT = WIDTH/(BLOCK*GPS) stages after the operand capture register.
// Optional feature macro: CSA_PIPE_OVF_EN (adds the ovf signed-overflow output).
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (in_ready is the global advance enable)
//   a, b, cin             operands and carry in
//   out_valid / out_ready result handshake
//   sum, cout             a+b+cin mod 2^WIDTH and carry out of the MSB
//   ovf                   signed overflow, aligned with sum (CSA_PIPE_OVF_EN only)

module csa_pipe #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 4,
    parameter int GPS   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef CSA_PIPE_OVF_EN
   ,output logic             ovf
`endif
);

    localparam int LAT = WIDTH / (BLOCK * GPS);

    if (WIDTH % (BLOCK * GPS) != 0) begin : g_bad_cfg
        $error("csa_pipe: WIDTH must be a multiple of BLOCK*GPS");
    end

    // Rank 0 is the operand capture register; rank k+1 holds the result of stage k.
    logic [LAT:0]       v_q;
    logic [LAT:0]       c_q;
    logic [WIDTH-1:0]   a_q   [LAT];
    logic [WIDTH-1:0]   b_q   [LAT];
    logic [WIDTH-1:0]   sum_q [LAT];
    logic [WIDTH-1:0]   sum_d [LAT];
    logic [LAT-1:0]     carry_d;
    logic               en;

    assign en        = ~v_q[LAT] | out_ready;
    assign in_ready  = en;
    assign out_valid = v_q[LAT];
    assign sum       = sum_q[LAT-1];
    assign cout      = c_q[LAT];

    // Stage k finishes groups k*GPS..k*GPS+GPS-1; lower sum bits come from the
    // previous stage register. The modulo index keeps the stage-0 read in range;
    // its value is discarded because stage 0 starts from all zeros.
    always_comb begin
        logic c, rc, p;
        c = 1'b0;
        rc = 1'b0;
        p = 1'b0;
        carry_d = '0;
        for (int k = 0; k < LAT; k++) begin
            sum_d[k] = (k == 0) ? '0 : sum_q[(k + LAT - 1) % LAT];
            c = c_q[k];
            for (int g = 0; g < GPS; g++) begin
                rc = c;
                p  = 1'b1;
                for (int i = 0; i < BLOCK; i++) begin
                    sum_d[k][(k*GPS+g)*BLOCK+i] = a_q[k][(k*GPS+g)*BLOCK+i]
                                                ^ b_q[k][(k*GPS+g)*BLOCK+i] ^ rc;
                    rc = (a_q[k][(k*GPS+g)*BLOCK+i] & b_q[k][(k*GPS+g)*BLOCK+i])
                       | (rc & (a_q[k][(k*GPS+g)*BLOCK+i] ^ b_q[k][(k*GPS+g)*BLOCK+i]));
                    p  = p & (a_q[k][(k*GPS+g)*BLOCK+i] ^ b_q[k][(k*GPS+g)*BLOCK+i]);
                end
                // Whole group propagates: the incoming carry bypasses the ripple chain.
                c = p ? c : rc;
            end
            carry_d[k] = c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            c_q <= '0;
            for (int k = 0; k < LAT; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                sum_q[k] <= '0;
            end
        end else if (en) begin
            v_q <= {v_q[LAT-1:0], in_valid};
            // Operands are only captured for real transfers so bubbles never carry X.
            if (in_valid) begin
                a_q[0] <= a;
                b_q[0] <= b;
                c_q[0] <= cin;
            end
            for (int k = 0; k < LAT; k++) begin
                c_q[k+1] <= carry_d[k];
                sum_q[k] <= sum_d[k];
            end
            for (int k = 1; k < LAT; k++) begin
                a_q[k] <= a_q[k-1];
                b_q[k] <= b_q[k-1];
            end
        end
    end

`ifdef CSA_PIPE_OVF_EN
    logic ovf_q;

    // Carry into the MSB is recovered as sum^a^b at that bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (en) begin
            ovf_q <= sum_d[LAT-1][WIDTH-1] ^ a_q[LAT-1][WIDTH-1]
                   ^ b_q[LAT-1][WIDTH-1] ^ carry_d[LAT-1];
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_csa_pipe.sv
// tb/tb_csa_pipe.sv - randomized scoreboard bench for csa_pipe

module tb_csa_pipe;

    parameter int W  = 32;
    parameter int BK = 4;
    parameter int GP = 2;
    localparam int LAT = W / (BK * GP);
    localparam int N_RAND = 10000;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          cin;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  sum;
    logic          cout;
`ifdef CSA_PIPE_OVF_EN
    logic          ovf;
`endif

    csa_pipe #(.WIDTH(W), .BLOCK(BK), .GPS(GP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef CSA_PIPE_OVF_EN
       ,.ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            n_chk  = 0;
    int            n_fail = 0;
    int            n_out  = 0;
    int            n_hold = 0;
    bit            acc;
    bit            hold_v = 1'b0;
    logic [W:0]    hold_val;
    logic [W+1:0]  q [$];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer addition, overflow from the two's complement sign rule.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
        logic [W:0] s;
        logic       ov;
        s  = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        ov = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
        return {ov, s};
    endfunction

    function automatic logic [W-1:0] rnd();
        logic [63:0] t;
        t = {$urandom, $urandom};
        if ($urandom_range(0, 7) == 0) t = '1;
        return t[W-1:0];
    endfunction

    // One clock cycle: observe at the falling edge, then let the rising edge act.
    task automatic step();
        logic [W+1:0] e;
        @(negedge clk);
        if (hold_v) begin
            n_hold++;
            check("hold_valid", out_valid, 1'b1);
            check("hold_data", {cout, sum}, hold_val);
        end
        check("in_ready_rule", in_ready, !out_valid || out_ready);
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("spurious_out", 1'b1, 1'b0);
            end else begin
                e = q.pop_front();
                check("sum", sum, e[W-1:0]);
                check("cout", cout, e[W]);
`ifdef CSA_PIPE_OVF_EN
                check("ovf", ovf, e[W+1]);
`endif
                n_out++;
            end
        end
        acc = in_valid && in_ready;
        if (acc) q.push_back(model(a, b, cin));
        hold_v   = out_valid && !out_ready;
        hold_val = {cout, sum};
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        int t;
        t = 0;
        in_valid = 1'b1;
        a = x;
        b = y;
        cin = c;
        do begin
            step();
            t++;
        end while (!acc && t < 50);
        if (!acc) check("send_timeout", 1'b0, 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        while (q.size() != 0 && t < 50) begin
            step();
            t++;
        end
        check("drain_empty", q.size(), 0);
    endtask

    initial begin
        int n, i, cyc, n0, h0, sent;
        bit newop;

        rst_n = 1'b0;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        out_ready = 1'b1;
        #1;
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_sum", sum, 0);
        check("reset_cout", cout, 1'b0);
`ifdef CSA_PIPE_OVF_EN
        check("reset_ovf", ovf, 1'b0);
`endif
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Latency: edges from the accepting edge until out_valid is seen.
        send(W'(5), W'(3), 1'b0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("latency", n, LAT);
        drain();

        // Full carry skip and signed-overflow corners.
        send('1, '0, 1'b1);
        send('1, W'(1), 1'b0);
        send({1'b0, {(W-1){1'b1}}}, W'(1), 1'b0);
        send({1'b1, {(W-1){1'b0}}}, {1'b1, {(W-1){1'b0}}}, 1'b0);
        drain();

        // Backpressure: 10 back-to-back adds, consumer stalls for four cycles.
        i = 0;
        cyc = 0;
        n0 = n_out;
        h0 = n_hold;
        newop = 1'b1;
        while (i < 10 && cyc < 100) begin
            if (newop) begin
                a = rnd();
                b = rnd();
                cin = 1'($urandom_range(0, 1));
                newop = 1'b0;
            end
            in_valid  = 1'b1;
            out_ready = !(cyc >= 5 && cyc <= 8);
            step();
            if (acc) begin
                i++;
                newop = 1'b1;
            end
            cyc++;
        end
        in_valid = 1'b0;
        drain();
        check("bp_count", n_out - n0, 10);
        check("bp_stalled", n_hold > h0, 1'b1);

        // Reset with three adds in flight: nothing may emerge afterwards.
        out_ready = 1'b1;
        repeat (3) send(rnd(), rnd(), 1'($urandom_range(0, 1)));
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_sum", sum, 0);
        check("midrst_cout", cout, 1'b0);
        q.delete();
        hold_v = 1'b0;
        n0 = n_out;
        repeat (2) step();
        rst_n = 1'b1;
        repeat (10) step();
        check("midrst_no_result", n_out - n0, 0);

        // Random traffic on both sides.
        sent = 0;
        cyc = 0;
        while (sent < N_RAND && cyc < 60000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            a         = rnd();
            b         = ($urandom_range(0, 7) == 0) ? ~a : rnd();
            cin       = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            step();
            if (acc) sent++;
            cyc++;
        end
        in_valid = 1'b0;
        check("random_sent", sent, N_RAND);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
